jtag_arbiter: RTL
=================

JTAG_ARBITER -- requirements
Module: jtag_arbiter

Interface
REQ-001 The block SHALL have parameter LEN_W, default 16, meaning the width of the transaction length field.
REQ-002 The block SHALL have parameter START_TO, default 8, meaning the maximum number of cycles between work and busy rising.
REQ-003 The block SHALL have parameter RUN_TO, default 200000, meaning the maximum number of cycles busy may stay high.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have ports req0/req1, input, 1 bit each: requester asks for one engine transaction.
REQ-007 The block SHALL have ports op0/op1, input, 1 bit each: transaction type, 1=data, 0=instruction.
REQ-008 The block SHALL have ports len0/len1, input, LEN_W bits each: transaction length in bits.
REQ-009 The block SHALL have ports gnt0/gnt1, output, 1 bit each: the requester owns the engine.
REQ-010 The block SHALL have ports done0/done1, output, 1 bit each: one-cycle pulse when the transaction ends.
REQ-011 The block SHALL have ports err0/err1, output, 1 bit each: one-cycle pulse, coincident with done, marking a failed or rejected transaction.
REQ-012 The block SHALL have port work, output, 1 bit: engine start pulse.
REQ-013 The block SHALL have port op, output, 1 bit: engine transaction type.
REQ-014 The block SHALL have port len, output, LEN_W bits: engine transaction length.
REQ-015 The block SHALL have port busy, input, 1 bit: the engine is executing a transaction.

Function
REQ-016 The FSM SHALL have states ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_RUN and ST_DONE.
REQ-017 In ST_IDLE with busy=0 and any req high, the block SHALL select a winner, latch its op/len into op/len, raise its gnt and go to ST_ISSUE on the next cycle.
REQ-018 Arbitration SHALL be round-robin: when both req are high, the requester not served last wins; with a single req, that requester wins.
REQ-019 ST_ISSUE SHALL assert work for exactly one cycle, then go to ST_WAIT_BUSY.
REQ-020 ST_WAIT_BUSY SHALL go to ST_RUN when busy=1.
REQ-021 ST_WAIT_BUSY SHALL flag an error and go to ST_DONE after START_TO cycles without busy.
REQ-022 ST_RUN SHALL go to ST_DONE when busy=0.
REQ-023 ST_RUN SHALL flag an error and go to ST_DONE after RUN_TO cycles with busy high.
REQ-024 ST_DONE SHALL pulse done (and err if flagged) for the granted requester for one cycle, drop gnt, update the last-served pointer and return to ST_IDLE.
REQ-025 If len is 0 at selection, the block SHALL not assert work and SHALL go straight to ST_DONE with err set; the pointer SHALL still update.
REQ-026 op and len SHALL hold their latched values from selection until ST_DONE, regardless of requester input changes.
REQ-027 At most one gnt SHALL be high at any time, and gnt SHALL be high only in ST_ISSUE..ST_DONE.
REQ-028 If req drops while its gnt is high, the transaction SHALL still complete with done.
REQ-029 The selection cycle SHALL NOT be re-entered in the same cycle as done; the earliest next grant is 1 cycle after done.
REQ-030 The watchdog counter SHALL be wide enough for RUN_TO, SHALL reset on each state entry, and SHALL saturate without wrapping.
REQ-031 If busy is already high in ST_IDLE (foreign engine activity), the block SHALL not grant until busy falls.

Reset
REQ-032 With rst high, the next clock SHALL force ST_IDLE; gnt*, done*, err*, work = 0; op = 0; len = 0; counter = 0; last-served = 1, so req0 wins first.
REQ-033 rst asserted mid-transaction SHALL abort without a done pulse; the engine is reset by the same rst.

Structure
REQ-034 Package jtag_pkg SHALL hold the arb_state_t enum, the OP_DATA/OP_INSTR constants and the LEN_W default.
REQ-035 One sub-module, jtag_rr_pick (2-way round-robin selector: req[1:0], last -> one-hot pick), SHALL be used; all else stays inline.

Verification
REQ-036 req0=1, op0=0, len0=10; engine model busy for 60 cycles -> gnt0 high, one work pulse, op=0, len=10, done0 pulse 1 cycle after busy falls, err0=0.
REQ-037 req0 and req1 high continuously, lengths 4 and 8 -> grants alternate 0,1,0,1; never both gnt high.
REQ-038 req1=1, len1=0 -> no work, done1 and err1 pulse within 3 cycles.
REQ-039 Engine model never raises busy, START_TO=8 -> done0 and err0 pulse 9-10 cycles after work.
REQ-040 RUN_TO=16, busy stuck high -> err pulse after 16 cycles in ST_RUN; no new grant until busy falls.
REQ-041 rst pulsed during ST_RUN -> all outputs 0 next cycle, no done; the next req0 is granted first.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG engine arbiter.
//   arb_state_t   : arbiter FSM state encoding
//   OP_DATA/INSTR : values of the op field (data vs instruction scan)
//   LEN_W_DEFAULT : default width of the transaction length field
package jtag_pkg;

   localparam int unsigned LEN_W_DEFAULT = 16;

   localparam logic OP_DATA  = 1'b1;
   localparam logic OP_INSTR = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_RUN,
      ST_DONE
   } arb_state_t;

endpackage

// File: rtl/jtag_rr_pick.sv
// Two-way round-robin selector.
//   req  : request vector, bit i = requester i
//   last : index of the requester served most recently
//   pick : one-hot winner (all zero when nobody requests)
module jtag_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick
);

   always_comb begin
      pick = 2'b00;
      if (req[0] && req[1]) begin
         // Contention: the requester not served last goes first.
         pick = last ? 2'b01 : 2'b10;
      end else if (req[0]) begin
         pick = 2'b01;
      end else if (req[1]) begin
         pick = 2'b10;
      end
   end

endmodule

// File: rtl/jtag_arbiter.sv
// Arbitrates two requesters onto a single JTAG shift engine.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   req0/req1     : requester wants one engine transaction
//   op0/op1       : transaction type per requester (1 = data, 0 = instruction)
//   len0/len1     : transaction length in bits per requester
//   gnt0/gnt1     : requester currently owns the engine
//   done0/done1   : one-cycle end-of-transaction pulse
//   err0/err1     : one-cycle pulse with done for a failed or rejected transaction
//   work, op, len : engine start pulse and the latched transaction descriptor
//   busy          : engine is executing a transaction
module jtag_arbiter
   import jtag_pkg::*;
#(
   parameter int unsigned LEN_W    = LEN_W_DEFAULT,
   parameter int unsigned START_TO = 8,
   parameter int unsigned RUN_TO   = 200000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic             op0,
   input  logic             op1,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic             err0,
   output logic             err1,
   output logic             work,
   output logic             op,
   output logic [LEN_W-1:0] len,
   input  logic             busy
);

   // The watchdog must hold the larger of the two timeouts without wrapping.
   localparam int unsigned      CNT_MAX   = (RUN_TO > START_TO) ? RUN_TO : START_TO;
   localparam int unsigned      CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO - 1);
   localparam logic [CNT_W-1:0] RUN_LIM   = CNT_W'(RUN_TO - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

   arb_state_t       state_q, state_d;
   logic [1:0]       gnt_q, gnt_d;
   logic             err_q, err_d;
   logic             op_q, op_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]       pick;
   logic             sel_op;
   logic [LEN_W-1:0] sel_len;

   jtag_rr_pick u_pick (
      .req  ({req1, req0}),
      .last (last_q),
      .pick (pick)
   );

   assign sel_op  = pick[1] ? op1  : op0;
   assign sel_len = pick[1] ? len1 : len0;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      err_d   = err_q;
      op_d    = op_q;
      len_d   = len_q;
      last_d  = last_q;

      unique case (state_q)
         ST_IDLE: begin
            // A busy engine here belongs to someone else; hold off until it frees up.
            if (!busy && (req0 || req1)) begin
               gnt_d = pick;
               op_d  = sel_op;
               len_d = sel_len;
               if (sel_len == '0) begin
                  // Zero-length work is rejected without touching the engine.
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (busy) begin
               state_d = ST_RUN;
            end else if (cnt_q == START_LIM) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_RUN: begin
            if (!busy) begin
               state_d = ST_DONE;
            end else if (cnt_q == RUN_LIM) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            gnt_d   = 2'b00;
            last_d  = gnt_q[1];
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 2'b00;
         end
      endcase

      // Cycle count within the current state; restarts on every transition.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_SAT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= 2'b00;
         err_q   <= 1'b0;
         op_q    <= OP_INSTR;
         len_q   <= '0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         err_q   <= err_d;
         op_q    <= op_d;
         len_q   <= len_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt0  = gnt_q[0];
   assign gnt1  = gnt_q[1];
   assign done0 = (state_q == ST_DONE) && gnt_q[0];
   assign done1 = (state_q == ST_DONE) && gnt_q[1];
   assign err0  = done0 && err_q;
   assign err1  = done1 && err_q;
   assign work  = (state_q == ST_ISSUE);
   assign op    = op_q;
   assign len   = len_q;

endmodule
